sys_cmd_decoder: RTL

- Command-frame decoder and system controller in the system-clock domain.
- Consumes bytes from the RX data synchronizer: `rx_data` is its `sync_bus`, `rx_valid` is its `enable_pulse`.
- Drives register-file writes/reads and ALU operations, gates the ALU clock, and returns response bytes to the TX path over a valid/ready handshake.

---
 rtl/sys_cmd_decoder.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder: command-frame decoder and system controller (system-clock domain).
//
// Consumes one byte per rx_valid pulse and decodes four frame types:
//   0xAA ADDR DATA       register write
//   0xBB ADDR            register read, 1-byte response
//   0xCC OPA OPB FUNC    write operands to regs 0/1, run ALU, 2-byte response (low first)
//   0xDD FUNC            run ALU on stored operands, 2-byte response (low first)
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   rx_data, rx_valid           incoming byte and its single-cycle valid pulse
//   rf_addr, rf_wr_en,
//   rf_wr_data, rf_rd_en        register-file access (strobes are 1-cycle pulses)
//   rf_rd_data, rf_rd_valid     register-file read return
//   alu_en, alu_func            ALU start pulse and held function code
//   alu_out, alu_out_valid      ALU result return
//   clk_gate_en                 ALU clock-gate enable, high in ALU_FUNC/ALU_WAIT
//   tx_data, tx_valid, tx_ready response byte handshake
//   busy                        frame in progress
//   err_cmd, err_drop,
//   err_timeout                 1-cycle error pulses
//
// Build option: define CMD_TIMEOUT_EN to abort partial frames after timeout_cycles
// idle cycles. Without it err_timeout is tied low and partial frames wait forever.

module sys_cmd_decoder #(
  parameter int unsigned bus_width      = 8,
  parameter int unsigned addr_width     = 4,
  parameter int unsigned func_width     = 4,
  parameter int unsigned alu_width      = 16,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bus_width-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic [addr_width-1:0] rf_addr,
  output logic                  rf_wr_en,
  output logic [bus_width-1:0]  rf_wr_data,
  output logic                  rf_rd_en,
  input  logic [bus_width-1:0]  rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  alu_en,
  output logic [func_width-1:0] alu_func,
  input  logic [alu_width-1:0]  alu_out,
  input  logic                  alu_out_valid,
  output logic                  clk_gate_en,
  output logic [bus_width-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err_cmd,
  output logic                  err_drop,
  output logic                  err_timeout
);

  localparam logic [bus_width-1:0] CmdWr    = bus_width'(8'hAA);
  localparam logic [bus_width-1:0] CmdRd    = bus_width'(8'hBB);
  localparam logic [bus_width-1:0] CmdAluOp = bus_width'(8'hCC);
  localparam logic [bus_width-1:0] CmdAluSt = bus_width'(8'hDD);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StOpa, StOpb,
    StAluFunc, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] rf_addr_q, rf_addr_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [bus_width-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic [func_width-1:0] alu_func_q, alu_func_d;
  logic [alu_width-1:0]  res_q, res_d;
  logic                  two_q, two_d;  // response has a high byte (ALU result)
  logic                  err_cmd_q, err_cmd_d;
  logic                  err_drop_q, err_drop_d;
  logic                  tmo_hit;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_data_d = rf_wr_data_q;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    alu_func_d   = alu_func_q;
    res_d        = res_q;
    two_d        = two_q;
    err_cmd_d    = 1'b0;
    err_drop_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          case (rx_data)
            CmdWr:    state_d = StWrAddr;
            CmdRd:    state_d = StRdAddr;
            CmdAluOp: state_d = StOpa;
            CmdAluSt: state_d = StAluFunc;
            default:  err_cmd_d = 1'b1;
          endcase
        end
      end
      StWrAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data[addr_width-1:0];
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = rx_data;
          state_d      = StIdle;
        end
      end
      StRdAddr: begin
        if (rx_valid) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_data[addr_width-1:0];
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        err_drop_d = rx_valid;
        if (rf_rd_valid) begin
          res_d   = {{(alu_width-bus_width){1'b0}}, rf_rd_data};
          two_d   = 1'b0;
          state_d = StTxLo;
        end
      end
      StOpa: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = '0;
          rf_wr_data_d = rx_data;
          state_d      = StOpb;
        end
      end
      StOpb: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_width'(1);
          rf_wr_data_d = rx_data;
          state_d      = StAluFunc;
        end
      end
      StAluFunc: begin
        if (rx_valid) begin
          alu_en_d   = 1'b1;
          alu_func_d = rx_data[func_width-1:0];
          state_d    = StAluWait;
        end
      end
      StAluWait: begin
        err_drop_d = rx_valid;
        if (alu_out_valid) begin
          res_d   = alu_out;
          two_d   = 1'b1;
          state_d = StTxLo;
        end
      end
      StTxLo: begin
        err_drop_d = rx_valid;
        if (tx_ready) state_d = two_q ? StTxHi : StIdle;
      end
      StTxHi: begin
        err_drop_d = rx_valid;
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // tmo_hit only fires without rx_valid, so nothing above has been updated.
    if (tmo_hit) state_d = StIdle;
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(timeout_cycles + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_state;
  logic            err_timeout_q;

  assign tmo_state = state_q inside {StWrAddr, StWrData, StRdAddr, StOpa, StOpb, StAluFunc};
  assign tmo_hit   = tmo_state && !rx_valid && (tmo_q == TmoW'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= tmo_hit;
      // Clear on any byte, on any state change, and while in non-timing states.
      if (rx_valid || (state_d != state_q) || !tmo_state) tmo_q <= '0;
      else                                                tmo_q <= tmo_q + 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_func_q   <= '0;
      res_q        <= '0;
      two_q        <= 1'b0;
      err_cmd_q    <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      alu_func_q   <= alu_func_d;
      res_q        <= res_d;
      two_q        <= two_d;
      err_cmd_q    <= err_cmd_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign rf_addr     = rf_addr_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign alu_en      = alu_en_q;
  assign alu_func    = alu_func_q;
  assign err_cmd     = err_cmd_q;
  assign err_drop    = err_drop_q;
  assign busy        = (state_q != StIdle);
  assign clk_gate_en = (state_q == StAluFunc) || (state_q == StAluWait);
  assign tx_valid    = (state_q == StTxLo) || (state_q == StTxHi);

  always_comb begin
    tx_data = '0;
    if (state_q == StTxLo)      tx_data = res_q[bus_width-1:0];
    else if (state_q == StTxHi) tx_data = res_q[alu_width-1:bus_width];
  end

endmodule
